// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_mux
// Brief    : N-way round-robin arbitrated mux with forced-select override and
//            a single full-throughput registered output stage (valid/ready).
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb_mux #(
  parameter  int WIDTH = 32,
  parameter  int N     = 32,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  input  logic               force_en,
  input  logic [SELW-1:0]    force_sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  logic              r_valid;
  logic [WIDTH-1:0]  r_data;
  logic [SELW-1:0]   r_sel;
  logic [SELW-1:0]   r_ptr;

  logic              w_rr_hit;
  logic [SELW-1:0]   w_rr_idx;
  logic              w_force_ok;
  logic              w_gnt_hit;
  logic [SELW-1:0]   w_gnt_idx;
  logic              w_load;
  logic              w_xfer;
  logic [SELW-1:0]   w_ptr_nxt;
  logic [WIDTH-1:0]  w_data;

  // Rotating priority scan: first valid channel at or after r_ptr, wrapping.
  always_comb begin
    int v_idx;
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    v_idx    = 0;
    for (int k = 0; k < N; k++) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= N) v_idx = v_idx - N;
      if (!w_rr_hit && in_valid[SELW'(v_idx)]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = SELW'(v_idx);
      end
    end
  end

  // Out-of-range force_sel is masked by the range test before in_valid is used.
  assign w_force_ok = (int'(force_sel) < N) && in_valid[force_sel];
  assign w_gnt_hit  = force_en ? w_force_ok : w_rr_hit;
  assign w_gnt_idx  = force_en ? force_sel  : w_rr_idx;
  assign w_load     = !r_valid || out_ready;
  assign w_xfer     = w_load && w_gnt_hit && !reset;
  assign w_ptr_nxt  = (w_gnt_idx == SELW'(N - 1)) ? '0 : w_gnt_idx + SELW'(1);

  always_comb begin
    w_data   = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt_idx == SELW'(i)) begin
        w_data      = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = w_xfer;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_data;
      r_sel   <= w_gnt_idx;
      if (!force_en) r_ptr <= w_ptr_nxt;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb_mux
// Brief    : Directed + randomized bench for rr_arb_mux (N=5 model, N=32 sweep).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb_mux;
  localparam int W  = 32;
  localparam int NA = 5;
  localparam int SA = 3;
  localparam int NB = 32;
  localparam int SB = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NA-1:0]   a_vld, a_rdy;
  logic [NA*W-1:0] a_dat;
  logic            a_fen, a_ov, a_ordy;
  logic [SA-1:0]   a_fsel, a_os;
  logic [W-1:0]    a_od;

  logic [NB-1:0]   b_vld, b_rdy;
  logic [NB*W-1:0] b_dat;
  logic            b_fen, b_ov, b_ordy;
  logic [SB-1:0]   b_fsel, b_os;
  logic [W-1:0]    b_od;

  rr_arb_mux #(.WIDTH(W), .N(NA)) u_dut_a (
    .clock(clk), .reset(rst), .in_valid(a_vld), .in_data(a_dat), .in_ready(a_rdy),
    .force_en(a_fen), .force_sel(a_fsel), .out_valid(a_ov), .out_data(a_od),
    .out_sel(a_os), .out_ready(a_ordy)
  );

  rr_arb_mux #(.WIDTH(W), .N(NB)) u_dut_b (
    .clock(clk), .reset(rst), .in_valid(b_vld), .in_data(b_dat), .in_ready(b_rdy),
    .force_en(b_fen), .force_sel(b_fsel), .out_valid(b_ov), .out_data(b_od),
    .out_sel(b_os), .out_ready(b_ordy)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference state for DUT A: output entry and round-robin pointer.
  bit          m_v;
  logic [W-1:0] m_d;
  int          m_s, m_p;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winner = lowest valid index >= ptr, else lowest valid index overall.
  task automatic model_grant(output bit hit, output int g);
    int above, lowest;
    above  = -1;
    lowest = -1;
    if (a_fen) begin
      g   = int'(a_fsel);
      hit = (g < NA) && a_vld[g];
    end else begin
      for (int i = NA - 1; i >= 0; i--) begin
        if (a_vld[i]) begin
          lowest = i;
          if (i >= m_p) above = i;
        end
      end
      g   = (above >= 0) ? above : lowest;
      hit = (g >= 0);
    end
    hit = hit && (!m_v || a_ordy) && !rst;
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic cycle();
    bit hit;
    int g;
    logic [NA-1:0] exp_rdy;
    #1;
    model_grant(hit, g);
    exp_rdy = '0;
    if (hit) exp_rdy[g] = 1'b1;
    chk("in_ready", 64'(a_rdy), 64'(exp_rdy));
    if (rst) begin
      m_v = 1'b0; m_d = '0; m_s = 0; m_p = 0;
    end else if (hit) begin
      m_v = 1'b1;
      m_d = a_dat[g*W +: W];
      m_s = g;
      if (!a_fen) m_p = (g + 1) % NA;
    end else if (a_ordy) begin
      m_v = 1'b0;
    end
    @(negedge clk);
    chk("out_valid", 64'(a_ov), 64'(m_v));
    chk("out_data",  64'(a_od), 64'(m_d));
    chk("out_sel",   64'(a_os), 64'(m_s));
  endtask

  task automatic drive(input logic [NA-1:0] v, input bit fen, input int fsel, input bit ordy);
    a_vld  = v;
    a_fen  = fen;
    a_fsel = SA'(fsel);
    a_ordy = ordy;
    for (int i = 0; i < NA; i++) a_dat[i*W +: W] = $urandom;
    cycle();
  endtask

  initial begin
    a_vld = '1; a_dat = '0; a_fen = 1'b0; a_fsel = '0; a_ordy = 1'b1;
    b_vld = '1; b_fen = 1'b0; b_fsel = '0; b_ordy = 1'b1;
    for (int i = 0; i < NB; i++) b_dat[i*W +: W] = 32'hA000_0000 + i;
    m_v = 1'b0; m_d = '0; m_s = 0; m_p = 0;
    @(negedge clk);

    // Reset with all valid, then first grant must be channel 0.
    rst = 1'b1;
    drive('1, 0, 0, 1);
    drive('1, 0, 0, 1);
    rst = 1'b0;
    drive('1, 0, 0, 1);
    drive('1, 0, 0, 1);

    // Sparse traffic on channels 1 and 4, then wrap to channel 0.
    repeat (4) drive(5'b10010, 0, 0, 1);
    drive(5'b00001, 0, 0, 1);
    chk("wrap_sel", 64'(a_os), 64'd0);

    // Backpressure: hold three cycles, then release with no bubble.
    drive('1, 0, 0, 1);
    repeat (3) drive('1, 0, 0, 0);
    repeat (3) drive('1, 0, 0, 1);

    // Forced mode: valid 1 and 3, force 3; then release; then absent and out-of-range.
    repeat (3) drive(5'b01010, 1, 3, 1);
    drive(5'b01010, 0, 0, 1);
    drive(5'b00010, 1, 3, 1);
    drive(5'b11111, 1, 6, 1);
    chk("force_oor_valid", 64'(a_ov), 64'd0);
    drive(5'b11111, 1, 7, 1);

    // Reset while an entry is held under backpressure.
    drive('1, 0, 0, 1);
    drive('1, 0, 0, 1);
    drive('1, 0, 0, 0);
    rst = 1'b1;
    drive('1, 0, 0, 0);
    rst = 1'b0;
    drive('1, 0, 0, 1);
    chk("post_reset_sel", 64'(a_os), 64'd0);

    // Sweep of the 32-way instance right after a reset.
    rst = 1'b1;
    drive('0, 0, 0, 1);
    rst = 1'b0;
    for (int k = 0; k < NB + 2; k++) begin
      drive('0, 0, 0, 1);
      chk("sweep_valid", 64'(b_ov), 64'd1);
      chk("sweep_sel",   64'(b_os), 64'(k % NB));
      chk("sweep_data",  64'(b_od), 64'(32'hA000_0000 + (k % NB)));
    end

    // Randomized traffic on the 5-way instance.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(NA'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 7),
            ($urandom_range(0, 9) < 7));
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
